// File: rtl/day9_pkg.sv
// Shared types for the day 9 rectangle accelerator: tile coordinates,
// the x+y / x-y projections used to pick extreme tiles, and area widths.
package day9_pkg;

   localparam int COORD_W     = 17;
   localparam int PIPE_STAGES = 6;

   typedef logic [COORD_W-1:0]          coord_t;
   typedef logic [COORD_W:0]            sum_t;    // x+y, never negative
   typedef logic signed [COORD_W:0]     diff_t;   // x-y, either sign
   typedef logic [COORD_W:0]            span_t;   // |dx|+1 reaches 2^W
   typedef logic [2*COORD_W+1:0]        area_t;   // full product, pre-saturation

   typedef struct packed {
      coord_t x;
      coord_t y;
   } point_t;

   typedef struct packed {
      point_t smax;
      point_t smin;
      point_t dmax;
      point_t dmin;
   } extremes_t;

   function automatic sum_t pt_sum(input point_t p);
      return {1'b0, p.x} + {1'b0, p.y};
   endfunction

   function automatic diff_t pt_diff(input point_t p);
      return $signed({1'b0, p.x}) - $signed({1'b0, p.y});
   endfunction

endpackage

// File: rtl/day9_rect_area.sv
// Two-stage pair-area unit: (|xa-xb|+1) * (|ya-yb|+1).
// Stage A registers the spans, stage B registers the full-width product.
module day9_rect_area
   import day9_pkg::*;
(
   input  logic   clock,
   input  logic   reset,
   input  point_t a,
   input  point_t b,
   output area_t  prod
);

   span_t dx_d, dx_q;
   span_t dy_d, dy_q;
   area_t prod_d, prod_q;

   // absolute coordinate differences, inclusive of both end tiles
   always_comb begin
      dx_d = (a.x >= b.x) ? span_t'({1'b0, a.x} - {1'b0, b.x})
                          : span_t'({1'b0, b.x} - {1'b0, a.x});
      dy_d = (a.y >= b.y) ? span_t'({1'b0, a.y} - {1'b0, b.y})
                          : span_t'({1'b0, b.y} - {1'b0, a.y});
      dx_d = dx_d + span_t'(1);
      dy_d = dy_d + span_t'(1);
   end

   // product of the two spans; full width so nothing wraps before saturation
   always_comb begin
      prod_d = area_t'(dx_q) * area_t'(dy_q);
   end

   // span and product registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dx_q   <= '0;
         dy_q   <= '0;
         prod_q <= '0;
      end else begin
         dx_q   <= dx_d;
         dy_q   <= dy_d;
         prod_q <= prod_d;
      end
   end

   assign prod = prod_q;

endmodule

// File: rtl/day9_puzzle1.sv
// Streaming largest-rectangle finder. Each tile is paired with the four
// extreme tiles (min/max of x+y and x-y) seen before it; the best pair
// area feeds a saturating running maximum on `area`.
module day9_puzzle1
   import day9_pkg::*;
#(
   parameter int W = COORD_W
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [W-1:0]   x_coord,
   input  logic [W-1:0]   y_coord,
   output logic [2*W-1:0] area
);

   localparam area_t AREA_MAX = area_t'({(2*W){1'b1}});

   logic [PIPE_STAGES-1:1] vld_d, vld_q;     // vld_q[k]: stage k holds a real tile
   point_t                 tile1_d, tile1_q;
   point_t                 tile2_d, tile2_q;
   extremes_t              ext_d, ext_q;
   logic                   ext_vld_d, ext_vld_q;
   extremes_t              snap_d, snap_q;   // extremes before this tile folded in
   logic                   first2_d, first2_q;
   logic                   first3_d, first3_q;
   logic                   first4_d, first4_q;
   area_t                  cand5_d, cand5_q;
   logic [2*W-1:0]         area_d, area_q;

   point_t [3:0]           pair_b;
   area_t  [3:0]           prod;

   // S1: every edge out of reset samples a tile
   always_comb begin
      tile1_d = '{x: coord_t'(x_coord), y: coord_t'(y_coord)};
      vld_d   = {vld_q[PIPE_STAGES-2:1], 1'b1};
   end

   // S2: snapshot old extremes for pairing, then fold the new tile in
   always_comb begin
      tile2_d   = tile1_q;
      snap_d    = ext_q;
      first2_d  = ~ext_vld_q;
      ext_d     = ext_q;
      ext_vld_d = ext_vld_q;
      if (vld_q[1]) begin
         if (!ext_vld_q) begin
            ext_d     = '{smax: tile1_q, smin: tile1_q, dmax: tile1_q, dmin: tile1_q};
            ext_vld_d = 1'b1;
         end else begin
            // strict compares: on ties the older tile stays
            if (pt_sum(tile1_q)  > pt_sum(ext_q.smax))  ext_d.smax = tile1_q;
            if (pt_sum(tile1_q)  < pt_sum(ext_q.smin))  ext_d.smin = tile1_q;
            if (pt_diff(tile1_q) > pt_diff(ext_q.dmax)) ext_d.dmax = tile1_q;
            if (pt_diff(tile1_q) < pt_diff(ext_q.dmin)) ext_d.dmin = tile1_q;
         end
      end
   end

   assign pair_b = {snap_q.dmin, snap_q.dmax, snap_q.smin, snap_q.smax};

   // S3/S4: one pair-area unit per extreme
   for (genvar i = 0; i < 4; i++) begin : g_rect
      day9_rect_area u_rect (
         .clock (clock),
         .reset (reset),
         .a     (tile2_q),
         .b     (pair_b[i]),
         .prod  (prod[i])
      );
   end

   // S5: best of the four pairings; the first tile only pairs with itself
   always_comb begin
      first3_d = first2_q;
      first4_d = first3_q;
      cand5_d  = prod[0];
      for (int i = 1; i < 4; i++) begin
         if (prod[i] > cand5_d) cand5_d = prod[i];
      end
      if (first4_q) cand5_d = area_t'(1);
   end

   // S6: saturating running maximum
   always_comb begin
      area_d = area_q;
      if (vld_q[PIPE_STAGES-1]) begin
         if (cand5_q > AREA_MAX)
            area_d = '1;
         else if (cand5_q[2*W-1:0] > area_q)
            area_d = cand5_q[2*W-1:0];
      end
   end

   // all pipeline and extreme state; reset discards in-flight tiles
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_q     <= '0;
         tile1_q   <= '0;
         tile2_q   <= '0;
         ext_q     <= '0;
         ext_vld_q <= 1'b0;
         snap_q    <= '0;
         first2_q  <= 1'b0;
         first3_q  <= 1'b0;
         first4_q  <= 1'b0;
         cand5_q   <= '0;
         area_q    <= '0;
      end else begin
         vld_q     <= vld_d;
         tile1_q   <= tile1_d;
         tile2_q   <= tile2_d;
         ext_q     <= ext_d;
         ext_vld_q <= ext_vld_d;
         snap_q    <= snap_d;
         first2_q  <= first2_d;
         first3_q  <= first3_d;
         first4_q  <= first4_d;
         cand5_q   <= cand5_d;
         area_q    <= area_d;
      end
   end

   assign area = area_q;

endmodule

// File: tb/tb_day9_puzzle1.sv
// Scoreboard bench for day9_puzzle1: a reference model scans the full tile
// history for the extreme tiles, and a monitor compares `area` every cycle.
module tb_day9_puzzle1;

   localparam int     W        = 17;
   localparam longint AREA_MAX = (64'd1 << (2*W)) - 1;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic [W-1:0]   x_coord = '0;
   logic [W-1:0]   y_coord = '0;
   logic [2*W-1:0] area;

   int checks   = 0;
   int failures = 0;
   longint cyc  = 0;

   typedef struct {
      longint due;
      longint exp;
   } sb_t;

   sb_t    sb[$];
   int     hx[$];
   int     hy[$];
   longint run_max = 0;

   day9_puzzle1 #(.W(W)) dut (
      .clock   (clock),
      .reset   (reset),
      .x_coord (x_coord),
      .y_coord (y_coord),
      .area    (area)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic longint pair_area(input int xa, input int ya, input int xb, input int yb);
      int dx, dy;
      dx = (xa > xb) ? xa - xb : xb - xa;
      dy = (ya > yb) ? ya - yb : yb - ya;
      return longint'(dx + 1) * longint'(dy + 1);
   endfunction

   // Reference: extremes by scanning every earlier tile, first occurrence wins ties.
   task automatic model_step(input int x, input int y, output longint exp);
      longint cand;
      int     ismax, ismin, idmax, idmin;
      longint a0, a1, a2, a3;
      if (hx.size() == 0) begin
         cand = 1;
      end else begin
         ismax = 0; ismin = 0; idmax = 0; idmin = 0;
         for (int i = 1; i < hx.size(); i++) begin
            if (hx[i] + hy[i] > hx[ismax] + hy[ismax]) ismax = i;
            if (hx[i] + hy[i] < hx[ismin] + hy[ismin]) ismin = i;
            if (hx[i] - hy[i] > hx[idmax] - hy[idmax]) idmax = i;
            if (hx[i] - hy[i] < hx[idmin] - hy[idmin]) idmin = i;
         end
         a0 = pair_area(x, y, hx[ismax], hy[ismax]);
         a1 = pair_area(x, y, hx[ismin], hy[ismin]);
         a2 = pair_area(x, y, hx[idmax], hy[idmax]);
         a3 = pair_area(x, y, hx[idmin], hy[idmin]);
         cand = a0;
         if (a1 > cand) cand = a1;
         if (a2 > cand) cand = a2;
         if (a3 > cand) cand = a3;
      end
      hx.push_back(x);
      hy.push_back(y);
      if (cand > run_max) run_max = cand;
      exp = (run_max > AREA_MAX) ? AREA_MAX : run_max;
   endtask

   // Stimulus side of the scoreboard: every sampled tile predicts `area` 5 edges later.
   initial forever begin
      longint e;
      sb_t    ent;
      @(posedge clock);
      cyc++;
      if (!reset) begin
         model_step(int'(x_coord), int'(y_coord), e);
         ent.due = cyc + 5;
         ent.exp = e;
         sb.push_back(ent);
      end
   end

   // Reset throws away both the model history and any pending predictions.
   initial forever begin
      @(posedge reset);
      sb.delete();
      hx.delete();
      hy.delete();
      run_max = 0;
   end

   // Monitor: compare whenever a prediction falls due.
   initial forever begin
      sb_t ent;
      @(negedge clock);
      if (reset) begin
         chk("area_in_reset", longint'(area), 0);
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
         ent = sb.pop_front();
         chk("sb_area", longint'(area), ent.exp);
      end
   end

   task automatic drive(input int x, input int y);
      x_coord = W'(x);
      y_coord = W'(y);
      @(posedge clock);
      #1;
   endtask

   task automatic hold(input int x, input int y, input int n);
      for (int i = 0; i < n; i++) drive(x, y);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_async", longint'(area), 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int ex_x[8];
      int ex_y[8];
      int n;
      int rng;
      ex_x = '{7, 11, 11, 9, 9, 2, 2, 7};
      ex_y = '{1, 1, 7, 7, 5, 5, 3, 3};

      #2;
      do_reset();

      // AoC example stream
      for (int i = 0; i < 8; i++) drive(ex_x[i], ex_y[i]);
      hold(7, 3, 5);
      chk("aoc_example", longint'(area), 50);

      // single tile: nothing visible until edge n+5
      do_reset();
      drive(5, 5);
      hold(5, 5, 4);
      chk("single_before", longint'(area), 0);
      drive(5, 5);
      chk("single_after", longint'(area), 1);

      // widest non-saturating pair
      do_reset();
      drive(0, 0);
      drive(99999, 99999);
      hold(99999, 99999, 5);
      chk("big_pair", longint'(area), 64'd10000000000);

      // duplicates keep the max stable
      do_reset();
      for (int r = 0; r < 4; r++) begin
         drive(3, 4); drive(1, 1); drive(3, 4);
      end
      chk("dup_12a", longint'(area), 12);
      for (int r = 0; r < 4; r++) begin
         drive(3, 4); drive(1, 1); drive(3, 4);
      end
      chk("dup_12b", longint'(area), 12);

      // mid-stream reset discards earlier tiles
      do_reset();
      drive(0, 0);
      drive(10, 10);
      hold(10, 10, 5);
      chk("pre_reset_121", longint'(area), 121);
      do_reset();
      drive(2, 2);
      drive(4, 3);
      hold(4, 3, 5);
      chk("post_reset_6", longint'(area), 6);

      // back-to-back tiles see the immediately preceding tile's extremes
      do_reset();
      drive(0, 0); drive(9, 0); drive(0, 9); drive(9, 9);
      hold(9, 9, 5);
      chk("b2b_100", longint'(area), 100);

      // full-range corners: 2^34 saturates to all ones
      do_reset();
      drive(0, 0);
      drive(131071, 131071);
      hold(131071, 131071, 5);
      chk("saturate", longint'(area), AREA_MAX);

      // randomized bursts: small ranges force ties, wide ranges stress width
      for (int b = 0; b < 6; b++) begin
         do_reset();
         rng = (b % 3 == 0) ? 15 : ((b % 3 == 1) ? 1000 : 131071);
         n   = $urandom_range(40, 120);
         for (int i = 0; i < n; i++)
            drive($urandom_range(0, rng), $urandom_range(0, rng));
      end
      hold(0, 0, 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
